// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus master-side blocks.
//   arb_state_e  : arbiter FSM states (IDLE, BUSY, GAP, LOCKED)
//   PORT_A/PORT_B: encoding of the registered grant / round-robin "last" bit
//   WRITE_*      : byte-strobe patterns for cpu_write / x_write (0 = read)
//   rr_pick()    : round-robin choice between the two requesters
package nubus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        GAP    = 2'd2,
        LOCKED = 2'd3
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [3:0] WRITE_NONE  = 4'b0000;
    localparam logic [3:0] WRITE_BYTE0 = 4'b0001;
    localparam logic [3:0] WRITE_HALF0 = 4'b0011;
    localparam logic [3:0] WRITE_HALF1 = 4'b1100;
    localparam logic [3:0] WRITE_WORD  = 4'b1111;

    // With both ports requesting, the port that was NOT served last wins.
    // Only meaningful when at least one request is present.
    function automatic logic rr_pick(input logic a_req, input logic b_req, input logic last);
        if (a_req && b_req) begin
            return ~last;
        end
        return b_req ? PORT_B : PORT_A;
    endfunction

endpackage

// File: rtl/nubus_lock_timer.sv
// Idle-lock timer for the master arbiter.
//   nub_clkn   : NuBus clock, rising edge
//   nub_resetn : asynchronous active-low reset
//   clear      : synchronous clear (wins over enable)
//   enable     : count one cycle
//   terminal   : high while enabled and the count sits at LIMIT-1
module nubus_lock_timer #(
    parameter int LIMIT = 64,
    parameter int W     = 8
) (
    input  logic nub_clkn,
    input  logic nub_resetn,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [W-1:0] count;

    // NOTE: state registers are written only with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/nubus_master_arbiter.sv
// Round-robin arbiter sharing the single NuBus master port between port A
// (host CPU) and port B (DMA engine), one transaction per grant, with bus
// lock for read-modify-write and a bounded idle-lock timeout.
//   nub_clkn, nub_resetn        : NuBus clock / async active-low reset
//   a_*, b_*                    : requester ports (valid held until ready)
//   cpu_*                       : to / from the nubus master core
//   grant_b                     : 1 while B owns the port (BUSY/LOCKED)
//   lock_timeout                : one-cycle pulse on forced lock release
module nubus_master_arbiter
    import nubus_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 64,
    parameter int TIMEOUT_W    = 8
) (
    input  logic        nub_clkn,
    input  logic        nub_resetn,

    input  logic        a_valid,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic [3:0]  a_write,
    input  logic        a_lock,
    output logic        a_ready,
    output logic [31:0] a_rdata,

    input  logic        b_valid,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    input  logic [3:0]  b_write,
    input  logic        b_lock,
    output logic        b_ready,
    output logic [31:0] b_rdata,

    output logic        cpu_valid,
    output logic [31:0] cpu_addr,
    output logic [31:0] cpu_wdata,
    output logic [3:0]  cpu_write,
    output logic        cpu_lock,
    input  logic        cpu_ready,
    input  logic [31:0] cpu_rdata,

    output logic        grant_b,
    output logic        lock_timeout
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       timeout_q, timeout_d;
    logic       timer_done;

    logic       in_busy;
    logic       in_locked;
    logic       own_valid;
    logic       own_lock;

    assign in_busy   = (state_q == BUSY);
    assign in_locked = (state_q == LOCKED);
    assign own_valid = (grant_q == PORT_B) ? b_valid : a_valid;
    assign own_lock  = (grant_q == PORT_B) ? b_lock  : a_lock;

    // Counts idle cycles while the lock is held; restarts from zero every
    // time LOCKED is entered because it is cleared whenever the next state
    // is anything else.
    nubus_lock_timer #(
        .LIMIT (LOCK_TIMEOUT),
        .W     (TIMEOUT_W)
    ) u_lock_timer (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .clear      (state_d != LOCKED),
        .enable     (in_locked),
        .terminal   (timer_done)
    );

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q   <= IDLE;
            grant_q   <= PORT_A;
            last_q    <= PORT_B;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_valid || b_valid) begin
                    grant_d = rr_pick(a_valid, b_valid, last_q);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Grant is held until completion even if valid drops.
                if (cpu_ready) begin
                    last_d  = grant_q;
                    state_d = own_lock ? LOCKED : GAP;
                end
            end
            GAP: begin
                // Keeps the requester's stale valid from being reissued.
                state_d = IDLE;
            end
            LOCKED: begin
                // Timeout has priority over a new request from the owner.
                if (timer_done) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (own_valid) begin
                    state_d = BUSY;
                end else if (!own_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are only presented while a transaction is in flight.
    assign cpu_valid = in_busy;
    assign cpu_addr  = in_busy ? ((grant_q == PORT_B) ? b_addr  : a_addr)  : '0;
    assign cpu_wdata = in_busy ? ((grant_q == PORT_B) ? b_wdata : a_wdata) : '0;
    assign cpu_write = in_busy ? ((grant_q == PORT_B) ? b_write : a_write) : '0;
    assign cpu_lock  = (in_busy && own_lock) || in_locked;

    // Completion is steered only through the registered grant.
    assign a_ready = in_busy && (grant_q == PORT_A) && cpu_ready;
    assign b_ready = in_busy && (grant_q == PORT_B) && cpu_ready;
    assign a_rdata = cpu_rdata;
    assign b_rdata = cpu_rdata;

    assign grant_b      = (grant_q == PORT_B) && (in_busy || in_locked);
    assign lock_timeout = timeout_q;

endmodule

// File: tb/tb_nubus_master_arbiter.sv
// Self-checking bench for nubus_master_arbiter: directed scenarios with
// literal expectations, then randomized requesters and a randomized
// completer checked every cycle against a transaction-level model.
module tb_nubus_master_arbiter;
    import nubus_pkg::*;

    localparam int LT = 8;
    localparam int TW = 8;

    logic        nub_clkn = 1'b0;
    logic        nub_resetn = 1'b0;

    logic        p_valid [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    logic [3:0]  p_write [2];
    logic        p_lock  [2];

    logic        a_ready, b_ready;
    logic [31:0] a_rdata, b_rdata;
    logic        cpu_valid, cpu_lock, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_write;
    logic        grant_b, lock_timeout;

    nubus_master_arbiter #(
        .LOCK_TIMEOUT (LT),
        .TIMEOUT_W    (TW)
    ) dut (
        .nub_clkn     (nub_clkn),
        .nub_resetn   (nub_resetn),
        .a_valid      (p_valid[0]),
        .a_addr       (p_addr[0]),
        .a_wdata      (p_wdata[0]),
        .a_write      (p_write[0]),
        .a_lock       (p_lock[0]),
        .a_ready      (a_ready),
        .a_rdata      (a_rdata),
        .b_valid      (p_valid[1]),
        .b_addr       (p_addr[1]),
        .b_wdata      (p_wdata[1]),
        .b_write      (p_write[1]),
        .b_lock       (p_lock[1]),
        .b_ready      (b_ready),
        .b_rdata      (b_rdata),
        .cpu_valid    (cpu_valid),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_write    (cpu_write),
        .cpu_lock     (cpu_lock),
        .cpu_ready    (cpu_ready),
        .cpu_rdata    (cpu_rdata),
        .grant_b      (grant_b),
        .lock_timeout (lock_timeout)
    );

    initial forever #5 nub_clkn = ~nub_clkn;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;
    bit slave_on = 1'b0;
    bit rand_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // m_owner : port holding the bus (-1 = nobody)
    // m_txn   : a transaction from m_owner is outstanding on the cpu side
    // m_held  : idle cycles spent so far holding the lock (-1 = not held)
    // m_gap   : one dead cycle after an unlocked completion
    int m_owner, m_last, m_held;
    bit m_txn, m_gap, m_pulse;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_held  = -1;
        m_txn   = 1'b0;
        m_gap   = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic model_step();
        bit pulse_next;
        pulse_next = 1'b0;
        if (m_txn) begin
            if (cpu_ready) begin
                m_last = m_owner;
                m_txn  = 1'b0;
                if (p_lock[m_owner]) m_held = 0;
                else begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end
            end
        end else if (m_held >= 0) begin
            if (m_held == LT - 1) begin
                pulse_next = 1'b1;
                m_owner    = -1;
                m_held     = -1;
            end else if (p_valid[m_owner]) begin
                m_txn  = 1'b1;
                m_held = -1;
            end else if (!p_lock[m_owner]) begin
                m_owner = -1;
                m_held  = -1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (p_valid[0] || p_valid[1]) begin
            if (p_valid[0] && p_valid[1]) m_owner = 1 - m_last;
            else m_owner = p_valid[0] ? 0 : 1;
            m_txn = 1'b1;
        end
        m_pulse = pulse_next;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge nub_clkn);
            if (nub_resetn) model_step();
            else model_reset();
        end
    end

    initial forever begin
        @(negedge nub_resetn);
        model_reset();
    end

    task automatic compare_cycle();
        logic exp_a_rdy, exp_b_rdy;
        exp_a_rdy = m_txn && (m_owner == 0) && cpu_ready;
        exp_b_rdy = m_txn && (m_owner == 1) && cpu_ready;
        check_bit("m_cpu_valid", cpu_valid, m_txn);
        if (m_txn) begin
            check("m_cpu_addr", cpu_addr, p_addr[m_owner]);
            check("m_cpu_wdata", cpu_wdata, p_wdata[m_owner]);
            check("m_cpu_write", 32'(cpu_write), 32'(p_write[m_owner]));
            check_bit("m_cpu_lock", cpu_lock, p_lock[m_owner]);
        end else begin
            check_bit("m_cpu_lock", cpu_lock, m_held >= 0);
        end
        check_bit("m_a_ready", a_ready, exp_a_rdy);
        check_bit("m_b_ready", b_ready, exp_b_rdy);
        check_bit("m_grant_b", grant_b, (m_txn || m_held >= 0) && m_owner == 1);
        check_bit("m_lock_timeout", lock_timeout, m_pulse);
        if (exp_a_rdy) check("m_a_rdata", a_rdata, cpu_rdata);
        if (exp_b_rdy) check("m_b_rdata", b_rdata, cpu_rdata);
    endtask

    initial forever begin
        @(negedge nub_clkn);
        if (cmp_on) compare_cycle();
    end

    // ---------------- randomized completer ----------------
    initial begin
        int lat;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        forever begin
            @(negedge nub_clkn);
            if (slave_on && nub_resetn && cpu_valid) begin
                lat = $urandom_range(0, 2);
                repeat (lat) @(posedge nub_clkn);
                @(posedge nub_clkn);
                #1;
                cpu_ready = 1'b1;
                cpu_rdata = $urandom;
                @(posedge nub_clkn);
                #1;
                cpu_ready = 1'b0;
                cpu_rdata = '0;
            end
        end
    end

    // ---------------- randomized requesters ----------------
    task automatic requester(input int p);
        int idle;
        int n;
        @(posedge nub_clkn);
        #1;
        forever begin
            if (!rand_on) begin
                @(posedge nub_clkn);
                #1;
            end else begin
                idle = ($urandom_range(0, 7) == 0) ? $urandom_range(LT, LT + 4)
                                                   : $urandom_range(0, 3);
                repeat (idle) begin
                    if ($urandom_range(0, 5) == 0) p_lock[p] = 1'b0;
                    @(posedge nub_clkn);
                    #1;
                end
                p_valid[p] = 1'b1;
                p_addr[p]  = $urandom;
                p_wdata[p] = $urandom;
                p_write[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : WRITE_NONE;
                p_lock[p]  = ($urandom_range(0, 2) == 0);
                n = 0;
                forever begin
                    @(negedge nub_clkn);
                    if ((p == 1) ? b_ready : a_ready) break;
                    n++;
                    if (n > 300) break;
                end
                check_bit($sformatf("req%0d_completes", p), (p == 1) ? b_ready : a_ready, 1'b1);
                @(posedge nub_clkn);
                #1;
                p_valid[p] = 1'b0;
            end
        end
    endtask

    initial requester(0);
    initial requester(1);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed helpers ----------------
    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            p_valid[i] = 1'b0;
            p_addr[i]  = '0;
            p_wdata[i] = '0;
            p_write[i] = WRITE_NONE;
            p_lock[i]  = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(posedge nub_clkn);
        #3 nub_resetn = 1'b0;
        repeat (2) @(posedge nub_clkn);
        #3 nub_resetn = 1'b1;
        @(posedge nub_clkn);
        #1;
    endtask

    task automatic next_cycle();
        @(posedge nub_clkn);
        #1;
    endtask

    // Pulse cpu_ready for the current cycle (called just after a negedge).
    task automatic pulse_ready(input logic [31:0] rd);
        #1;
        cpu_ready = 1'b1;
        cpu_rdata = rd;
        #1;
    endtask

    initial begin
        int n;
        clear_inputs();
        cmp_on = 1'b1;

        // Reset state
        repeat (2) @(posedge nub_clkn);
        #1;
        check_bit("rst_cpu_valid", cpu_valid, 1'b0);
        check_bit("rst_a_ready", a_ready, 1'b0);
        check_bit("rst_b_ready", b_ready, 1'b0);
        check_bit("rst_cpu_lock", cpu_lock, 1'b0);
        check_bit("rst_grant_b", grant_b, 1'b0);
        check_bit("rst_lock_timeout", lock_timeout, 1'b0);
        check("rst_cpu_addr", cpu_addr, 32'h0);
        #3 nub_resetn = 1'b1;
        next_cycle();

        // Single A write
        p_valid[0] = 1'b1;
        p_addr[0]  = 32'hF000_0000;
        p_wdata[0] = 32'h8765_4321;
        p_write[0] = WRITE_WORD;
        @(negedge nub_clkn);
        check_bit("a_write_sample_cycle", cpu_valid, 1'b0);
        next_cycle();
        @(negedge nub_clkn);
        check_bit("a_write_cpu_valid", cpu_valid, 1'b1);
        check("a_write_addr", cpu_addr, 32'hF000_0000);
        check("a_write_wdata", cpu_wdata, 32'h8765_4321);
        check("a_write_strobes", 32'(cpu_write), 32'hF);
        pulse_ready(32'h0);
        check_bit("a_write_a_ready", a_ready, 1'b1);
        check_bit("a_write_b_ready", b_ready, 1'b0);
        next_cycle();
        cpu_ready = 1'b0;
        p_valid[0] = 1'b0;
        @(negedge nub_clkn);
        check_bit("a_write_gap", cpu_valid, 1'b0);
        next_cycle();

        // Both valid from reset: strict alternation A,B,A,B,...
        apply_reset();
        clear_inputs();
        p_valid[0] = 1'b1;
        p_addr[0]  = 32'h1000_0000;
        p_valid[1] = 1'b1;
        p_addr[1]  = 32'h2000_0000;
        slave_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                @(negedge nub_clkn);
                n++;
            end while (!(a_ready || b_ready) && n < 100);
            check_bit($sformatf("alt_%0d_a", i), a_ready, (i % 2) == 0);
            check_bit($sformatf("alt_%0d_b", i), b_ready, (i % 2) == 1);
        end
        next_cycle();
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        slave_on = 1'b0;
        repeat (4) next_cycle();

        // Locked read-modify-write by A with B pending
        apply_reset();
        clear_inputs();
        p_valid[0] = 1'b1;
        p_addr[0]  = 32'hF000_0004;
        p_lock[0]  = 1'b1;
        p_valid[1] = 1'b1;
        p_addr[1]  = 32'hA000_0000;
        p_write[1] = WRITE_WORD;
        next_cycle();
        @(negedge nub_clkn);
        check_bit("rmw_rd_grant_b", grant_b, 1'b0);
        check("rmw_rd_addr", cpu_addr, 32'hF000_0004);
        check_bit("rmw_rd_lock", cpu_lock, 1'b1);
        pulse_ready(32'h1234_5678);
        next_cycle();
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        p_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge nub_clkn);
            check_bit($sformatf("rmw_hold_lock_%0d", i), cpu_lock, 1'b1);
            check_bit($sformatf("rmw_hold_grant_b_%0d", i), grant_b, 1'b0);
            next_cycle();
        end
        p_valid[0] = 1'b1;
        p_write[0] = WRITE_WORD;
        p_wdata[0] = 32'h1234_5679;
        p_lock[0]  = 1'b0;
        next_cycle();
        @(negedge nub_clkn);
        check_bit("rmw_wr_valid", cpu_valid, 1'b1);
        check_bit("rmw_wr_grant_b", grant_b, 1'b0);
        check("rmw_wr_strobes", 32'(cpu_write), 32'hF);
        pulse_ready(32'h0);
        next_cycle();
        cpu_ready = 1'b0;
        p_valid[0] = 1'b0;
        repeat (2) next_cycle();
        @(negedge nub_clkn);
        check_bit("rmw_then_b_grant", grant_b, 1'b1);
        check("rmw_then_b_addr", cpu_addr, 32'hA000_0000);
        pulse_ready(32'h0);
        next_cycle();
        cpu_ready = 1'b0;
        p_valid[1] = 1'b0;
        repeat (3) next_cycle();

        // Lock timeout with B pending
        apply_reset();
        clear_inputs();
        p_valid[0] = 1'b1;
        p_addr[0]  = 32'hF000_000C;
        p_lock[0]  = 1'b1;
        p_valid[1] = 1'b1;
        p_addr[1]  = 32'hB000_0000;
        next_cycle();
        cpu_ready = 1'b1;
        next_cycle();
        cpu_ready = 1'b0;
        p_valid[0] = 1'b0;
        n = 0;
        forever begin
            @(negedge nub_clkn);
            if (lock_timeout || n > 4 * LT) break;
            n++;
        end
        check("timeout_cycles", n, LT);
        check_bit("timeout_pulse", lock_timeout, 1'b1);
        check_bit("timeout_unlock", cpu_lock, 1'b0);
        next_cycle();
        @(negedge nub_clkn);
        check_bit("timeout_pulse_once", lock_timeout, 1'b0);
        check_bit("timeout_b_granted", grant_b, 1'b1);
        pulse_ready(32'h0);
        next_cycle();
        cpu_ready = 1'b0;
        p_valid[1] = 1'b0;
        p_lock[0]  = 1'b0;
        repeat (3) next_cycle();

        // Reset mid-BUSY, then a B read with data routing
        apply_reset();
        clear_inputs();
        p_valid[0] = 1'b1;
        p_addr[0]  = 32'hF000_0010;
        p_valid[1] = 1'b1;
        p_addr[1]  = 32'hF000_0008;
        next_cycle();
        @(negedge nub_clkn);
        check_bit("pre_reset_busy", cpu_valid, 1'b1);
        #2 nub_resetn = 1'b0;
        cpu_ready = 1'b1;
        #1;
        check_bit("rst_busy_cpu_valid", cpu_valid, 1'b0);
        check_bit("rst_busy_a_ready", a_ready, 1'b0);
        check_bit("rst_busy_grant_b", grant_b, 1'b0);
        check("rst_busy_cpu_addr", cpu_addr, 32'h0);
        next_cycle();
        cpu_ready = 1'b0;
        p_valid[0] = 1'b0;
        @(posedge nub_clkn);
        #3 nub_resetn = 1'b1;
        next_cycle();
        @(negedge nub_clkn);
        check_bit("post_reset_b_grant", grant_b, 1'b1);
        check("post_reset_b_addr", cpu_addr, 32'hF000_0008);
        pulse_ready(32'h0000_BEEF);
        check_bit("b_read_ready", b_ready, 1'b1);
        check("b_read_rdata", b_rdata, 32'h0000_BEEF);
        check_bit("b_read_a_ready", a_ready, 1'b0);
        next_cycle();
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        p_valid[1] = 1'b0;
        repeat (3) next_cycle();

        // Randomized traffic against the model
        apply_reset();
        clear_inputs();
        slave_on = 1'b1;
        rand_on  = 1'b1;
        repeat (3000) @(posedge nub_clkn);
        rand_on = 1'b0;
        repeat (100) @(posedge nub_clkn);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nubus_master_arbiter.md
Name: nubus_master_arbiter

Overview:
- Shares the single NuBus master port (cpu_* interface of the nubus core) between two requesters: port A (host CPU) and port B (DMA/secondary engine).
- Round-robin arbitration, one transaction per grant, and lock support for atomic read-modify-write sequences.
- Lock hold is bounded by a timeout so one requester cannot starve the other.
- Sits between the requesters and the nubus master inputs, clocked from the NuBus clock.

Parameters:
- LOCK_TIMEOUT, 64: maximum cycles a lock may be held idle between locked transactions before forced release (>=2).
- TIMEOUT_W, 8: width of the lock timeout counter; must hold LOCK_TIMEOUT.

Ports:
- nub_clkn  in  1  NuBus clock; all state updates on rising edge.
- nub_resetn  in  1  asynchronous, active-low reset.
- a_valid  in  1  port A request; held high until a_ready.
- a_addr  in  32  port A address.
- a_wdata  in  32  port A write data.
- a_write  in  4  port A byte strobes; 0 = read.
- a_lock  in  1  port A requests bus lock after this transaction.
- a_ready  out  1  port A completion pulse.
- a_rdata  out  32  port A read data, valid with a_ready.
- b_valid, b_addr, b_wdata, b_write, b_lock, b_ready, b_rdata: as port A, for port B.
- cpu_valid  out  1  to nubus master.
- cpu_addr  out  32  to nubus master.
- cpu_wdata  out  32  to nubus master.
- cpu_write  out  4  to nubus master.
- cpu_lock  out  1  to nubus master.
- cpu_ready  in  1  from nubus master; one-cycle completion pulse.
- cpu_rdata  in  32  from nubus master.
- grant_b  out  1  debug: 1 = B owns the port.
- lock_timeout  out  1  one-cycle pulse on forced lock release.

Behaviour:
- Reset (async, nub_resetn low):
  - state = IDLE, grant_b = 0, last = B (so A wins the first tie), counter = 0.
  - All outputs 0, including cpu_valid, a_ready, b_ready, cpu_lock and lock_timeout.
  - Reset mid-transaction abandons it silently; no ready is issued.
- States: IDLE, BUSY, GAP, LOCKED.
- IDLE:
  - Only one valid pending: grant it.
  - Both valid: grant the port not in `last`.
  - Grant is registered; cpu_valid rises the cycle after the request is sampled (1-cycle latency).
  - Next state BUSY.
- BUSY:
  - cpu_valid = 1.
  - cpu_addr, cpu_wdata and cpu_write are muxed combinationally from the granted port.
  - cpu_lock = granted port's lock.
  - The non-granted port's ready stays 0.
  - On cpu_ready: granted port's ready = cpu_ready (same cycle, combinational); rdata = cpu_rdata; `last` <= granted port.
  - After cpu_ready: if the granted lock = 1, go to LOCKED, else go to GAP.
  - Grant is held until cpu_ready even if the requester drops valid (protocol violation; transaction still completes).
- GAP:
  - One cycle, cpu_valid = 0, so the requester's stale valid is not reissued.
  - Next state IDLE.
- LOCKED:
  - cpu_valid = 0 and cpu_lock = 1; grant held; the other port is ignored.
  - Counter increments each cycle.
  - Owner valid seen, on the cycle after its ready deasserted: counter cleared, go to BUSY.
  - Owner lock dropped with valid low: go to IDLE.
  - Counter reaches LOCK_TIMEOUT-1: lock_timeout pulse, go to IDLE.
  - Simultaneous owner valid and timeout: timeout wins.
- rdata outputs: a_rdata and b_rdata both carry cpu_rdata; only the qualified ready is meaningful.
- grant_b reflects the registered grant in BUSY and LOCKED; it is 0 in IDLE and GAP.
- Timing: no combinational path from a_valid/b_valid to cpu_valid; the cpu_ready to x_ready path is combinational through the registered grant only.

Decomposition:
- Shared package nubus_pkg:
  - arbiter state enum (IDLE, BUSY, GAP, LOCKED);
  - port-select constant (PORT_A = 0, PORT_B = 1);
  - WRITE_* strobe constants already used by the testbenches.
- Optional sub-module nubus_lock_timer: the loadable/clearable counter with terminal-count pulse. Everything else stays in one module.

Test Plan:
- Single A write (a_write=4'b1111, addr F0000000, data 87654321): cpu_valid rises 1 cycle after a_valid; a_ready pulses with cpu_ready; b_ready stays 0; one GAP cycle follows.
- A and B asserted together from reset: A granted first, B granted after A's GAP. Repeat with both continuously valid and check strict alternation A,B,A,B over 8 transactions.
- A locked RMW: a_lock=1 read F0000004 then write F0000004 with b_valid held high. B is not granted until A's second transaction completes with a_lock=0, and cpu_lock stays 1 between the two transactions.
- Lock timeout: A completes with a_lock=1 then goes idle with a_lock held. lock_timeout pulses exactly LOCK_TIMEOUT cycles after entering LOCKED, and pending B is granted next.
- Reset mid-BUSY (nub_resetn low while cpu_valid=1): all outputs 0 immediately (async). After release, a pending B request is granted normally.
- Read data routing: B read of F0000008 with cpu_rdata=0000BEEF gives b_rdata=0000BEEF with b_ready; a_ready stays 0.
